nn_layer_sequencer: RTL and testbench

// Time-multiplexed controller for one dense layer of the speech-recognition network.

---
 rtl/nn_layer_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// Sequences one dense layer over a single MAC: bias load, L multiply-accumulates,
// then a ReLU/saturated write per neuron, chained to the next layer via start/done.
module nn_layer_sequencer #(
  parameter int IN_W    = 16,
  parameter int W_W     = 8,
  parameter int ACC_W   = 40,
  parameter int MAX_IN  = 1024,
  parameter int MAX_OUT = 1024,
  parameter int WA_W    = 20,
  localparam int AW     = $clog2(MAX_IN + 1),
  localparam int OW     = $clog2(MAX_OUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   cfg_in_len,
  input  logic [OW-1:0]   cfg_out_len,
  input  logic [WA_W-1:0] cfg_w_base,
  input  logic            cfg_relu,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   in_addr,
  input  logic [IN_W-1:0] in_data,
  output logic [WA_W-1:0] w_addr,
  input  logic [W_W-1:0]  w_data,
  output logic [OW-1:0]   b_addr,
  input  logic [W_W-1:0]  b_data,
  output logic            out_we,
  output logic [OW-1:0]   out_addr,
  output logic [IN_W-1:0] out_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_WRITE,
    S_FINISH
  } state_t;

  localparam int PW = IN_W + W_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};

  state_t state, state_n;

  logic [AW-1:0]   l_q, k, k_n, k_inc, in_addr_n;
  logic [OW-1:0]   n_q, j, j_n, j_inc, b_addr_n, out_addr_n;
  logic [WA_W-1:0] w_ptr, w_ptr_n, w_addr_n;
  logic            relu_q, fold_bias, fold_mac, accept;
  logic [PW-1:0]   in_ext, w_ext, prod;
  logic signed [ACC_W-1:0] acc, acc_next, relu_val;
  logic [IN_W-1:0] sat_val, out_data_q;

  assign accept = (state == S_IDLE) && start;
  assign k_inc  = k + 1'b1;
  assign j_inc  = j + 1'b1;

  // Handshake: start is a one-cycle request honoured only in IDLE; done is a
  // one-cycle completion pulse in FINISH, where busy has already dropped.
  assign busy   = (state == S_BIAS) || (state == S_MAC) || (state == S_WRITE);
  assign done   = (state == S_FINISH);
  assign out_we = (state == S_WRITE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Addresses are registered on the transition into the issuing state, so
  // they stay put whenever nothing is being issued.
  always_comb begin
    state_n    = state;
    j_n        = j;
    k_n        = k;
    w_ptr_n    = w_ptr;
    in_addr_n  = in_addr;
    w_addr_n   = w_addr;
    b_addr_n   = b_addr;
    out_addr_n = out_addr;
    case (state)
      S_IDLE: begin
        if (start) begin
          j_n     = '0;
          w_ptr_n = cfg_w_base;
          if (cfg_out_len == '0) begin
            state_n = S_FINISH;
          end else begin
            state_n  = S_BIAS;
            b_addr_n = '0;
          end
        end
      end
      S_BIAS: begin
        k_n = '0;
        if (l_q == '0) begin
          state_n    = S_WRITE;
          out_addr_n = j;
        end else begin
          state_n   = S_MAC;
          in_addr_n = '0;
          w_addr_n  = w_ptr;
          w_ptr_n   = w_ptr + 1'b1;
        end
      end
      S_MAC: begin
        if (k_inc == l_q) begin
          state_n    = S_WRITE;
          out_addr_n = j;
        end else begin
          k_n       = k_inc;
          in_addr_n = k_inc;
          w_addr_n  = w_ptr;
          w_ptr_n   = w_ptr + 1'b1;
        end
      end
      S_WRITE: begin
        j_n = j_inc;
        if (j_inc == n_q) begin
          state_n = S_FINISH;
        end else begin
          state_n  = S_BIAS;
          b_addr_n = j_inc;
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // ROM data arrives one cycle after issue, so the fold is driven by what
  // the previous cycle issued rather than by the current state.
  always_comb begin
    in_ext   = {{W_W{in_data[IN_W-1]}}, in_data};
    w_ext    = {{IN_W{w_data[W_W-1]}}, w_data};
    prod     = in_ext * w_ext;
    acc_next = acc;
    if (fold_bias)     acc_next = {{(ACC_W-W_W){b_data[W_W-1]}}, b_data};
    else if (fold_mac) acc_next = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
    relu_val = (relu_q && acc_next[ACC_W-1]) ? '0 : acc_next;
    if (relu_val > SAT_MAX)      sat_val = SAT_MAX[IN_W-1:0];
    else if (relu_val < SAT_MIN) sat_val = SAT_MIN[IN_W-1:0];
    else                         sat_val = relu_val[IN_W-1:0];
  end

  assign out_data = (state == S_WRITE) ? sat_val : out_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      j          <= '0;
      k          <= '0;
      w_ptr      <= '0;
      in_addr    <= '0;
      w_addr     <= '0;
      b_addr     <= '0;
      out_addr   <= '0;
      acc        <= '0;
      fold_bias  <= 1'b0;
      fold_mac   <= 1'b0;
      out_data_q <= '0;
      l_q        <= '0;
      n_q        <= '0;
      relu_q     <= 1'b0;
    end else begin
      j         <= j_n;
      k         <= k_n;
      w_ptr     <= w_ptr_n;
      in_addr   <= in_addr_n;
      w_addr    <= w_addr_n;
      b_addr    <= b_addr_n;
      out_addr  <= out_addr_n;
      acc       <= acc_next;
      fold_bias <= (state == S_BIAS);
      fold_mac  <= (state == S_MAC);
      if (state == S_WRITE) out_data_q <= sat_val;
      if (accept) begin
        l_q    <= cfg_in_len;
        n_q    <= cfg_out_len;
        relu_q <= cfg_relu;
      end
    end
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Randomized and directed bench for nn_layer_sequencer: ROM models, a driver,
// an arithmetic reference model feeding expected queues, and a write/done monitor.
module tb_nn_layer_sequencer;

  localparam int AW = 11;
  localparam int OW = 11;

  logic            clk, rst, start, cfg_relu, busy, done, out_we;
  logic [AW-1:0]   cfg_in_len, in_addr;
  logic [OW-1:0]   cfg_out_len, b_addr, out_addr;
  logic [19:0]     cfg_w_base, w_addr;
  logic [15:0]     in_data, out_data;
  logic [7:0]      w_data, b_data;

  nn_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_in_len(cfg_in_len), .cfg_out_len(cfg_out_len),
    .cfg_w_base(cfg_w_base), .cfg_relu(cfg_relu),
    .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data),
    .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous ROM / buffer models
  logic [15:0] in_mem [0:2047];
  logic [7:0]  b_mem  [0:2047];
  logic [7:0]  w_mem  [logic [19:0]];

  function automatic logic [7:0] w_rd(input logic [19:0] a);
    return w_mem.exists(a) ? w_mem[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    in_data <= in_mem[in_addr];
    b_data  <= b_mem[b_addr];
    w_data  <= w_rd(w_addr);
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [15:0]   exp_q[$];
  logic [OW-1:0] exp_addr_q[$];
  int            exp_cyc_q[$];
  int            done_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (out_we) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected no write (cycle %0d)",
                 out_addr, out_data, cyc);
      end else begin
        logic [15:0]   d;
        logic [OW-1:0] a;
        int            c;
        d = exp_q.pop_front();
        a = exp_addr_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("write_addr", longint'(out_addr), longint'(a));
        check("write_data", longint'(out_data), longint'(d));
        check("write_cycle", longint'(cyc), longint'(c));
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        int c;
        c = done_q.pop_front();
        check("done_cycle", longint'(cyc), longint'(c));
        check("busy_at_done", longint'(busy), 0);
      end
    end
  end

  // reference model: plain dot product per neuron, then ReLU and clamp
  task automatic predict(input int l, input int n, input bit relu, input int base, input int c_s);
    for (int j = 0; j < n; j++) begin
      longint acc;
      acc = longint'($signed(b_mem[j]));
      for (int k = 0; k < l; k++)
        acc += longint'($signed(in_mem[k])) * longint'($signed(w_rd(20'(base + j * l + k))));
      if (relu && acc < 0) acc = 0;
      if (acc > 32767)  acc = 32767;
      if (acc < -32768) acc = -32768;
      exp_q.push_back(16'(acc));
      exp_addr_q.push_back(OW'(j));
      exp_cyc_q.push_back(c_s + (j + 1) * (l + 2));
    end
    done_q.push_back(c_s + n * (l + 2) + 1);
  endtask

  task automatic rand_mem(input int l, input int n, input int base);
    w_mem.delete();
    for (int k = 0; k < l; k++) in_mem[k] = 16'($urandom);
    for (int j = 0; j < n; j++) b_mem[j] = 8'($urandom);
    for (int i = 0; i < n * l; i++) w_mem[20'(base + i)] = 8'($urandom);
  endtask

  task automatic scramble_cfg();
    cfg_in_len  = AW'($urandom);
    cfg_out_len = OW'($urandom);
    cfg_w_base  = 20'($urandom);
    cfg_relu    = 1'($urandom);
  endtask

  task automatic drain_check(input string name);
    check({name, "_writes_left"}, longint'(exp_q.size()), 0);
    check({name, "_done_left"}, longint'(done_q.size()), 0);
  endtask

  // driver: one full layer with garbage cfg and stray starts while busy
  task automatic run_layer(input int l, input int n, input bit relu, input int base);
    int  c_s;
    bit  got_done;
    @(negedge clk);
    cfg_in_len  = AW'(l);
    cfg_out_len = OW'(n);
    cfg_w_base  = 20'(base);
    cfg_relu    = relu;
    start       = 1'b1;
    c_s         = cyc;
    predict(l, n, relu, base, c_s);
    @(negedge clk);
    start = 1'b0;
    scramble_cfg();
    check("busy_after_start", longint'(busy), longint'(n != 0));
    got_done = 1'b0;
    for (int t = 0; t < n * (l + 2) + 20; t++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      start = busy && ($urandom_range(0, 3) == 0);
      scramble_cfg();
      @(negedge clk);
    end
    if (!got_done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done by cycle %0d", c_s + n * (l + 2) + 1);
      exp_q.delete(); exp_addr_q.delete(); exp_cyc_q.delete(); done_q.delete();
      start = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end else begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      start = 1'b0;
      check("idle_after_finish", longint'(busy), 0);
      @(negedge clk);
      drain_check("layer");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int l, n, base;
    rst = 1'b1;
    start = 1'b0;
    cfg_in_len = '0; cfg_out_len = '0; cfg_w_base = '0; cfg_relu = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      in_mem[i] = '0;
      b_mem[i]  = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_out_we", longint'(out_we), 0);
    check("rst_in_addr", longint'(in_addr), 0);
    check("rst_w_addr", longint'(w_addr), 0);
    check("rst_b_addr", longint'(b_addr), 0);
    check("rst_out_addr", longint'(out_addr), 0);
    check("rst_out_data", longint'(out_data), 0);

    // start in the same cycle as reset is dropped by reset
    cfg_in_len = 11'd2; cfg_out_len = 11'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    check("rst_beats_start", longint'(busy), 0);

    // small hand-checkable layer
    w_mem.delete();
    in_mem[0] = 16'd3; in_mem[1] = 16'hFFFE;
    w_mem[20'd100] = 8'd4; w_mem[20'd101] = 8'd5;
    b_mem[0] = 8'd10;
    run_layer(2, 1, 1'b1, 100);
    b_mem[0] = 8'hEC;
    run_layer(2, 1, 1'b1, 100);
    run_layer(2, 1, 1'b0, 100);

    // positive and negative saturation
    w_mem.delete();
    for (int k = 0; k < 4; k++) begin
      in_mem[k] = 16'h7FFF;
      w_mem[20'(500 + k)] = 8'd127;
    end
    b_mem[0] = 8'd127;
    run_layer(4, 1, 1'b0, 500);
    for (int k = 0; k < 4; k++) w_mem[20'(500 + k)] = 8'h80;
    run_layer(4, 1, 1'b0, 500);
    run_layer(4, 1, 1'b1, 500);

    // bias-only layer and empty layer
    b_mem[0] = 8'd5; b_mem[1] = 8'hFF; b_mem[2] = 8'd7;
    run_layer(0, 3, 1'b0, 0);
    run_layer(0, 0, 1'b1, 0);

    // abort mid-MAC: nothing further may be written or signalled
    rand_mem(8, 4, 3000);
    @(negedge clk);
    cfg_in_len = 11'd8; cfg_out_len = 11'd4; cfg_w_base = 20'd3000; cfg_relu = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    check("abort_in_addr", longint'(in_addr), 0);
    check("abort_w_addr", longint'(w_addr), 0);
    repeat (40) @(negedge clk);
    drain_check("abort");
    run_layer(8, 4, 1'b0, 3000);

    // randomized layers, including a full-length one near the top of the weight space
    for (int r = 0; r < 12; r++) begin
      l    = $urandom_range(0, 40);
      n    = $urandom_range(0, 6);
      base = $urandom_range(0, 20'hFF000);
      rand_mem(l, n, base);
      run_layer(l, n, 1'($urandom_range(0, 1)), base);
    end
    rand_mem(1024, 2, 20'hFF7FF);
    run_layer(1024, 2, 1'b0, 20'hFF7FF);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
